hg_round_ctrl: RTL

- Parametrised N-player Halli Galli round controller. Generalises the fixed two-player turn/score path to N_PLAYERS, configurable colour/number ranges, bell target and deck size.
- Owns the turn FSM, per-player face-up top cards, the shared pile count, bell arbitration and judging, scores, and game-over/winner detection.
- Sits between the keypad/card source (upstream) and the LED/7-seg/LCD display blocks (downstream).

---
 rtl/hg_pkg.sv | 32 +++
 rtl/hg_bell_arbiter.sv | 30 +++
 rtl/hg_round_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hg_pkg.sv
// hg_pkg: shared types and helpers for the Halli Galli round controller.
//   state_t    - round FSM states (IDLE, FLIP, JUDGE, DONE)
//   width_of   - bit width needed to index/encode n values (minimum 1)
//   sat_add    - unsigned add clamped to a maximum
//   sat_sub    - unsigned subtract clamped at zero
package hg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLIP,
        JUDGE,
        DONE
    } state_t;

    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned sat_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned max_v);
        logic [63:0] s;
        s = 64'(a) + 64'(b);
        return (s > 64'(max_v)) ? max_v : 32'(s);
    endfunction

    function automatic int unsigned sat_sub(input int unsigned a,
                                            input int unsigned b);
        return (a >= b) ? (a - b) : 0;
    endfunction

endpackage

// File: rtl/hg_bell_arbiter.sv
// hg_bell_arbiter: fixed-priority picker, lowest eligible index wins.
//   i_req   - per-player bell presses
//   i_mask  - 1 = player eligible
//   o_grant - index of the winning player
//   o_any   - at least one eligible press
module hg_bell_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_mask,
    output logic [PW-1:0] o_grant,
    output logic          o_any
);

    logic w_found;

    always_comb begin
        w_found = 1'b0;
        o_grant = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_req[i] && i_mask[i] && !w_found) begin
                o_grant = PW'(i);
                w_found = 1'b1;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/hg_round_ctrl.sv
// hg_round_ctrl: N-player Halli Galli round controller (turns, table cards,
// bell judging, scores, game-over/winner).
//   clk/rst       - clock, synchronous active-low reset
//   start         - begin a game from IDLE or DONE
//   card_*        - card source handshake (valid/ready, colour, number)
//   bell          - per-player bell press pulses
//   turn          - player whose card flips next
//   top_*         - flattened face-up cards, player 0 in LSBs
//   pile_cnt      - face-up cards on the table
//   score         - flattened scores, player 0 in LSBs
//   result_*      - judge outcome, valid during JUDGE
//   game_over/winner/tie - final standing, held in DONE
// Optional: define BELL_LOCKOUT_EN to mask a wrong ringer's bell until the
// next accepted card.
module hg_round_ctrl
    import hg_pkg::*;
#(
    parameter int unsigned N_PLAYERS = 2,
    parameter int unsigned N_COLORS  = 4,
    parameter int unsigned MAX_NUM   = 5,
    parameter int unsigned BELL_SUM  = 5,
    parameter int unsigned DECK_SIZE = 56,
    parameter int unsigned SCORE_W   = 9,
    parameter int unsigned PENALTY   = 1,
    localparam int unsigned CW = width_of(N_COLORS),
    localparam int unsigned NW = width_of(MAX_NUM + 1),
    localparam int unsigned PW = width_of(N_PLAYERS),
    localparam int unsigned DW = width_of(DECK_SIZE + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      card_valid,
    input  logic [CW-1:0]             card_color,
    input  logic [NW-1:0]             card_num,
    output logic                      card_ready,
    input  logic [N_PLAYERS-1:0]      bell,
    output logic [PW-1:0]             turn,
    output logic [N_PLAYERS-1:0]      top_valid,
    output logic [N_PLAYERS*CW-1:0]   top_color,
    output logic [N_PLAYERS*NW-1:0]   top_num,
    output logic [DW-1:0]             pile_cnt,
    output logic [N_PLAYERS*SCORE_W-1:0] score,
    output logic                      result_valid,
    output logic                      result_hit,
    output logic [PW-1:0]             result_player,
    output logic                      game_over,
    output logic [PW-1:0]             winner,
    output logic                      tie
);

    localparam int unsigned SUMW      = width_of(N_PLAYERS * MAX_NUM + 1);
    localparam int unsigned SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;

    state_t               r_state, w_state_nxt;
    logic [PW-1:0]        r_turn;
    logic [N_PLAYERS-1:0] r_top_valid;
    logic [CW-1:0]        r_top_color [N_PLAYERS];
    logic [NW-1:0]        r_top_num   [N_PLAYERS];
    logic [DW-1:0]        r_pile, r_dealt;
    logic [SCORE_W-1:0]   r_score     [N_PLAYERS];
    logic [SCORE_W-1:0]   w_score_nxt [N_PLAYERS];
    logic [PW-1:0]        r_bell_p, r_winner, w_win;
    logic                 r_hit, r_tie, w_tie;
    logic [SCORE_W-1:0]   w_best;
    logic [N_PLAYERS-1:0] w_mask;
    logic [PW-1:0]        w_grant;
    logic                 w_bell_any, w_hit, w_accept, w_start_game;
    logic                 w_deck_empty, w_bell_idle;
    logic [NW-1:0]        w_card_val;
    logic [SUMW-1:0]      w_sum;

    assign w_deck_empty = (r_dealt == DW'(DECK_SIZE));
    assign w_bell_idle  = (bell == '0);
    assign w_accept     = card_ready && card_valid;
    assign w_start_game = start && ((r_state == IDLE) || (r_state == DONE));

    // Malformed cards still occupy a slot but contribute nothing to a sum,
    // which also keeps the per-colour sum within SUMW.
    assign w_card_val = ((card_num == '0) || (32'(card_num) > MAX_NUM) ||
                         (32'(card_color) >= N_COLORS)) ? '0 : card_num;

`ifdef BELL_LOCKOUT_EN
    logic [N_PLAYERS-1:0] r_lock;

    always_ff @(posedge clk) begin
        if (!rst || w_start_game || w_accept) begin
            r_lock <= '0;
        end else if (r_state == JUDGE && !r_hit) begin
            for (int unsigned p = 0; p < N_PLAYERS; p++) begin
                if (PW'(p) == r_bell_p) r_lock[p] <= 1'b1;
            end
        end
    end

    assign w_mask = ~r_lock;
`else
    assign w_mask = '1;
`endif

    hg_bell_arbiter #(
        .N  (N_PLAYERS),
        .PW (PW)
    ) u_arb (
        .i_req   (bell),
        .i_mask  (w_mask),
        .o_grant (w_grant),
        .o_any   (w_bell_any)
    );

    always_comb begin
        w_hit = 1'b0;
        w_sum = '0;
        for (int unsigned c = 0; c < N_COLORS; c++) begin
            w_sum = '0;
            for (int unsigned p = 0; p < N_PLAYERS; p++) begin
                if (r_top_valid[p] && (32'(r_top_color[p]) == c))
                    w_sum = w_sum + SUMW'(r_top_num[p]);
            end
            if (32'(w_sum) == BELL_SUM) w_hit = 1'b1;
        end
    end

    // Scores as they will be after this edge; the DONE-entry standings are
    // taken from these so a final JUDGE is reflected.
    always_comb begin
        for (int unsigned p = 0; p < N_PLAYERS; p++) begin
            w_score_nxt[p] = r_score[p];
            if (r_state == JUDGE && PW'(p) == r_bell_p) begin
                if (r_hit)
                    w_score_nxt[p] = SCORE_W'(sat_add(32'(r_score[p]), 32'(r_pile), SCORE_MAX));
                else
                    w_score_nxt[p] = SCORE_W'(sat_sub(32'(r_score[p]), PENALTY));
            end
        end
    end

    always_comb begin
        w_best = w_score_nxt[0];
        w_win  = '0;
        w_tie  = 1'b0;
        for (int unsigned p = 1; p < N_PLAYERS; p++) begin
            if (w_score_nxt[p] > w_best) begin
                w_best = w_score_nxt[p];
                w_win  = PW'(p);
                w_tie  = 1'b0;
            end else if (w_score_nxt[p] == w_best) begin
                w_tie = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = FLIP;
            FLIP: begin
                if (w_bell_any)                       w_state_nxt = JUDGE;
                else if (w_deck_empty && w_bell_idle) w_state_nxt = DONE;
            end
            JUDGE:   w_state_nxt = w_deck_empty ? DONE : FLIP;
            DONE:    if (start) w_state_nxt = FLIP;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        card_ready    = (r_state == FLIP) && w_bell_idle && !w_deck_empty;
        result_valid  = (r_state == JUDGE);
        result_hit    = (r_state == JUDGE) && r_hit;
        result_player = r_bell_p;
        game_over     = (r_state == DONE);
        winner        = r_winner;
        tie           = r_tie;
        turn          = r_turn;
        top_valid     = r_top_valid;
        pile_cnt      = r_pile;
        top_color     = '0;
        top_num       = '0;
        score         = '0;
        for (int unsigned p = 0; p < N_PLAYERS; p++) begin
            top_color[p*CW +: CW]          = r_top_color[p];
            top_num[p*NW +: NW]            = r_top_num[p];
            score[p*SCORE_W +: SCORE_W]    = r_score[p];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || w_start_game) begin
            r_turn      <= '0;
            r_top_valid <= '0;
            r_pile      <= '0;
            r_dealt     <= '0;
            for (int unsigned p = 0; p < N_PLAYERS; p++) begin
                r_top_color[p] <= '0;
                r_top_num[p]   <= '0;
                r_score[p]     <= '0;
            end
        end else begin
            if (w_accept) begin
                for (int unsigned p = 0; p < N_PLAYERS; p++) begin
                    if (PW'(p) == r_turn) begin
                        r_top_color[p] <= card_color;
                        r_top_num[p]   <= w_card_val;
                        r_top_valid[p] <= 1'b1;
                    end
                end
                r_pile  <= r_pile + DW'(1);
                r_dealt <= r_dealt + DW'(1);
                r_turn  <= (r_turn == PW'(N_PLAYERS - 1)) ? '0 : r_turn + PW'(1);
            end
            if (r_state == JUDGE) begin
                for (int unsigned p = 0; p < N_PLAYERS; p++) r_score[p] <= w_score_nxt[p];
                if (r_hit) begin
                    r_pile      <= '0;
                    r_top_valid <= '0;
                    r_turn      <= r_bell_p;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bell_p <= '0;
            r_hit    <= 1'b0;
            r_winner <= '0;
            r_tie    <= 1'b0;
        end else begin
            if (r_state == FLIP && w_bell_any) begin
                r_bell_p <= w_grant;
                r_hit    <= w_hit;
            end
            if (w_state_nxt == DONE && r_state != DONE) begin
                r_winner <= w_win;
                r_tie    <= w_tie;
            end
        end
    end

endmodule
